// File: rtl/riscv_zero_fetch.sv
// riscv_zero_fetch: instruction fetch stage.
// Owns the fetch PC and keeps a single request outstanding to instruction
// memory. It presents one registered instruction to decode, parks one more
// in a hold buffer while decode stalls, and squashes stale fetches when
// execute redirects the PC.
module riscv_zero_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst_data,
  output logic [31:0] pc_out,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic [31:0] hold_data;
  logic [31:0] hold_pc;
  logic        drop;
  logic        req_fire;
  logic        unused_redirect_lsbs;

  // The target is always word aligned, so the low redirect bits carry no information.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // A request is presented only in S_REQ and never while reset is held.
  assign imem_req_valid = (state == S_REQ) && !reset;
  assign imem_addr      = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Fetch FSM, output register and hold buffer; redirect outranks everything but reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_REQ;
      fetch_pc   <= RESET_PC;
      drop       <= 1'b0;
      inst_valid <= 1'b0;
      inst_data  <= NOP_INST;
      pc_out     <= '0;
    end else if (redirect_valid) begin
      fetch_pc   <= {redirect_pc[31:2], 2'b00};
      inst_valid <= 1'b0;
      inst_data  <= NOP_INST;
      unique case (state)
        S_REQ: begin
          // An address accepted this cycle is already stale: eat its response.
          if (req_fire) begin
            drop  <= 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            drop  <= 1'b0;
            state <= S_REQ;
          end else begin
            drop  <= 1'b1;
          end
        end
        default: begin
          // Leaving S_HOLD discards the buffered instruction.
          state <= S_REQ;
        end
      endcase
    end else begin
      // Decode took the current instruction; a load below overrides this.
      if (inst_valid && !stall) begin
        inst_valid <= 1'b0;
        inst_data  <= NOP_INST;
      end
      unique case (state)
        S_REQ: begin
          if (req_fire) begin
            pend_pc  <= fetch_pc;
            fetch_pc <= fetch_pc + 32'd4;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else if (!inst_valid || !stall) begin
              inst_data  <= imem_rsp_data;
              pc_out     <= pend_pc;
              inst_valid <= 1'b1;
              state      <= S_REQ;
            end else begin
              hold_data <= imem_rsp_data;
              hold_pc   <= pend_pc;
              state     <= S_HOLD;
            end
          end
        end
        default: begin
          // S_HOLD: output register is occupied and stalled; release when decode frees it.
          if (!stall) begin
            inst_data  <= hold_data;
            pc_out     <= hold_pc;
            inst_valid <= 1'b1;
            state      <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_zero_fetch.sv
// tb_riscv_zero_fetch: directed bench for riscv_zero_fetch with a small
// instruction memory model of programmable response latency.
module tb_riscv_zero_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] inst_data;
  logic [31:0] pc_out;
  logic        inst_valid;

  // second instance: wrap-around reset PC, free-running memory
  logic        stall2 = 1'b0;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic        req_valid2;
  logic        req_ready2 = 1'b1;
  logic [31:0] addr2;
  logic        rsp_valid2 = 1'b0;
  logic [31:0] rsp_data2 = '0;
  logic [31:0] inst_data2;
  logic [31:0] pc_out2;
  logic        inst_valid2;

  int n_chk  = 0;
  int n_pass = 0;
  int rsp_delay = 1;
  int cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  riscv_zero_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_data      (inst_data),
    .pc_out         (pc_out),
    .inst_valid     (inst_valid)
  );

  riscv_zero_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall2),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .imem_req_valid (req_valid2),
    .imem_req_ready (req_ready2),
    .imem_addr      (addr2),
    .imem_rsp_valid (rsp_valid2),
    .imem_rsp_data  (rsp_data2),
    .inst_data      (inst_data2),
    .pc_out         (pc_out2),
    .inst_valid     (inst_valid2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_0113;
      default:       return {a[23:0], 8'h13};
    endcase
  endfunction

  // memory model for dut: response rsp_delay cycles after acceptance
  always @(posedge clk) begin
    if (reset) begin
      pend           <= 1'b0;
      imem_rsp_valid <= 1'b0;
    end else begin
      imem_rsp_valid <= 1'b0;
      if (imem_req_valid && imem_req_ready) begin
        if (rsp_delay <= 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= mem_word(imem_addr);
        end else begin
          pend      <= 1'b1;
          pend_addr <= imem_addr;
          cnt       <= rsp_delay - 1;
        end
      end else if (pend) begin
        if (cnt == 1) begin
          imem_rsp_valid <= 1'b1;
          imem_rsp_data  <= mem_word(pend_addr);
          pend           <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // memory model for dut2: always ready, one-cycle response
  always @(posedge clk) begin
    if (reset) rsp_valid2 <= 1'b0;
    else       rsp_valid2 <= req_valid2 && req_ready2;
    rsp_data2 <= mem_word(addr2);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    // reset state
    check_eq("rst_req_valid", imem_req_valid, 1'b0);
    check_eq("rst_inst_valid", inst_valid, 1'b0);
    check_eq("rst_inst_data", inst_data, 32'h0000_0013);
    check_eq("rst_pc_out", pc_out, 32'h0);
    check_eq("rst_req_valid2", req_valid2, 1'b0);

    // C0: first request
    reset = 1'b0;
    #1;
    check_eq("c0_req_valid", imem_req_valid, 1'b1);
    check_eq("c0_addr", imem_addr, 32'h0);
    check_eq("c0_addr2", addr2, 32'hFFFF_FFFC);
    check_eq("c0_req_valid2", req_valid2, 1'b1);
    tick(); // C1
    check_eq("c1_req_valid", imem_req_valid, 1'b0);
    tick(); // C2
    check_eq("c2_inst_valid", inst_valid, 1'b1);
    check_eq("c2_pc_out", pc_out, 32'h0);
    check_eq("c2_inst_data", inst_data, 32'h00A0_0093);
    check_eq("c2_addr", imem_addr, 32'h4);
    check_eq("c2_addr2_wrap", addr2, 32'h0);
    check_eq("c2_req_valid2", req_valid2, 1'b1);
    check_eq("c2_pc_out2", pc_out2, 32'hFFFF_FFFC);
    check_eq("c2_inst_data2", inst_data2, 32'hFFFF_FC13);
    tick(); // C3
    check_eq("c3_inst_valid", inst_valid, 1'b0);
    check_eq("c3_inst_data", inst_data, 32'h0000_0013);
    tick(); // C4
    check_eq("c4_pc_out", pc_out, 32'h4);
    check_eq("c4_inst_data", inst_data, 32'h0010_0113);
    check_eq("c4_addr", imem_addr, 32'h8);
    tick(); // C5
    tick(); // C6
    check_eq("c6_inst_valid", inst_valid, 1'b1);
    check_eq("c6_pc_out", pc_out, 32'h8);
    check_eq("c6_inst_data", inst_data, 32'h0000_0813);

    // stall for four cycles: output frozen, next word parked in the hold buffer
    stall = 1'b1;
    for (int i = 7; i <= 9; i++) begin
      tick();
      check_eq($sformatf("c%0d_stall_pc", i), pc_out, 32'h8);
      check_eq($sformatf("c%0d_stall_data", i), inst_data, 32'h0000_0813);
      check_eq($sformatf("c%0d_stall_valid", i), inst_valid, 1'b1);
      if (i >= 8) check_eq($sformatf("c%0d_no_req", i), imem_req_valid, 1'b0);
    end
    tick(); // C10
    stall = 1'b0;
    rsp_delay = 3;
    check_eq("c10_pc_out", pc_out, 32'h8);
    check_eq("c10_no_req", imem_req_valid, 1'b0);
    tick(); // C11
    check_eq("c11_pc_out", pc_out, 32'hC);
    check_eq("c11_inst_data", inst_data, 32'h0000_0C13);
    check_eq("c11_addr", imem_addr, 32'h10);
    check_eq("c11_req_valid", imem_req_valid, 1'b1);

    // redirect while waiting on the 0x10 response
    tick(); // C12
    check_eq("c12_inst_valid", inst_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick(); // C13
    redirect_valid = 1'b0;
    rsp_delay = 1;
    check_eq("c13_inst_valid", inst_valid, 1'b0);
    check_eq("c13_inst_data", inst_data, 32'h0000_0013);
    check_eq("c13_req_valid", imem_req_valid, 1'b0);
    tick(); // C14: stale response present
    check_eq("c14_req_valid", imem_req_valid, 1'b0);
    tick(); // C15
    check_eq("c15_addr", imem_addr, 32'h100);
    check_eq("c15_req_valid", imem_req_valid, 1'b1);
    check_eq("c15_inst_valid", inst_valid, 1'b0);
    tick(); // C16
    tick(); // C17
    check_eq("c17_inst_valid", inst_valid, 1'b1);
    check_eq("c17_pc_out", pc_out, 32'h100);
    check_eq("c17_inst_data", inst_data, 32'h0001_0013);

    // redirect to 0x20 with no handshake, then redirect during the 0x20 handshake
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    tick(); // C18
    check_eq("c18_addr", imem_addr, 32'h20);
    check_eq("c18_req_valid", imem_req_valid, 1'b1);
    check_eq("c18_inst_valid", inst_valid, 1'b0);
    imem_req_ready = 1'b1;
    redirect_pc = 32'h203;
    tick(); // C19
    redirect_valid = 1'b0;
    check_eq("c19_req_valid", imem_req_valid, 1'b0);
    tick(); // C20
    check_eq("c20_addr", imem_addr, 32'h200);
    check_eq("c20_req_valid", imem_req_valid, 1'b1);
    check_eq("c20_inst_valid", inst_valid, 1'b0);
    tick(); // C21
    tick(); // C22
    check_eq("c22_inst_valid", inst_valid, 1'b1);
    check_eq("c22_pc_out", pc_out, 32'h200);
    check_eq("c22_inst_data", inst_data, 32'h0002_0013);

    // reset asserted while waiting on the 0x204 response
    tick(); // C23
    check_eq("c23_req_valid", imem_req_valid, 1'b0);
    reset = 1'b1;
    imem_req_ready = 1'b0;
    tick(); // C24
    check_eq("c24_inst_valid", inst_valid, 1'b0);
    check_eq("c24_inst_data", inst_data, 32'h0000_0013);
    check_eq("c24_pc_out", pc_out, 32'h0);
    check_eq("c24_req_valid", imem_req_valid, 1'b0);
    reset = 1'b0;

    // memory not ready for three cycles: request and address held
    for (int i = 25; i <= 27; i++) begin
      tick();
      check_eq($sformatf("c%0d_wait_valid", i), imem_req_valid, 1'b1);
      check_eq($sformatf("c%0d_wait_addr", i), imem_addr, 32'h0);
    end
    imem_req_ready = 1'b1;
    tick(); // C28
    check_eq("c28_req_valid", imem_req_valid, 1'b0);
    tick(); // C29
    check_eq("c29_inst_valid", inst_valid, 1'b1);
    check_eq("c29_pc_out", pc_out, 32'h0);
    check_eq("c29_inst_data", inst_data, 32'h00A0_0093);
    check_eq("c29_addr", imem_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
